// File: rtl/life_counter_pkg.sv
// rtl/life_counter_pkg.sv - shared state encodings, default life limits and life arithmetic helpers
package life_counter_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  localparam logic [3:0] DEF_INIT_LIVES = 4'd3;
  localparam logic [3:0] DEF_MAX_LIVES  = 4'd9;

  // One more life, pinned at the ceiling so the HUD never draws past its limit
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] ceil);
    return (v >= ceil) ? ceil : v + 4'd1;
  endfunction

  // Smaller of two life counts
  function automatic logic [3:0] min_lives(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? b : a;
  endfunction

endpackage

// File: rtl/life_invuln_timer.sv
// rtl/life_invuln_timer.sv - frame-counted invulnerability window with sprite blink toggle
module life_invuln_timer #(
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter logic [3:0] BLINK_FRAMES  = 4'd8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  input  logic i_frame_tick,
  output logic o_done,
  output logic o_blink
);

  logic [7:0] r_frames;
  logic [3:0] r_blink_cnt;
  logic       r_blink;
  logic       w_tick;

  assign w_tick  = i_run & i_frame_tick;
  assign o_done  = w_tick & (r_frames <= 8'd1);
  assign o_blink = r_blink;

  // Load on a hit, count frames down while running, blink starts lit and flips every BLINK_FRAMES ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frames    <= 8'd0;
      r_blink_cnt <= 4'd0;
      r_blink     <= 1'b0;
    end else if (i_load) begin
      r_frames    <= INVULN_FRAMES;
      r_blink_cnt <= 4'd0;
      r_blink     <= 1'b1;
    end else if (!i_run || o_done) begin
      r_frames    <= 8'd0;
      r_blink_cnt <= 4'd0;
      r_blink     <= 1'b0;
    end else if (w_tick) begin
      r_frames <= r_frames - 8'd1;
      if (r_blink_cnt + 4'd1 >= BLINK_FRAMES) begin
        r_blink_cnt <= 4'd0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/life_counter.sv
// rtl/life_counter.sv - life bookkeeping FSM with invulnerability window; optional bonus lives via BONUS_LIFE_EN
module life_counter
  import life_counter_pkg::*;
#(
  parameter logic [3:0] INIT_LIVES    = DEF_INIT_LIVES,
  parameter logic [3:0] MAX_LIVES     = DEF_MAX_LIVES,
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter logic [3:0] BLINK_FRAMES  = 4'd8,
  parameter logic [7:0] BONUS_POINTS  = 8'd50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       collision,
  input  logic       frame_tick,
  input  logic       score_tick,
  output logic [3:0] life_number,
  output logic       invincible,
  output logic       life_blink,
  output logic       life_lost_pulse,
  output logic       game_over
);

  localparam logic [3:0] LOAD_LIVES = (INIT_LIVES > MAX_LIVES) ? MAX_LIVES : INIT_LIVES;

  logic [1:0] r_state;
  logic [3:0] r_lives;
  logic       r_invincible;
  logic       r_pulse;
  logic       r_game_over;
  logic       w_start;
  logic       w_hit;
  logic       w_bonus;
  logic       w_timer_load;
  logic       w_timer_done;
  logic       w_blink;

  assign w_start      = game_start & ((r_state == S_IDLE) | (r_state == S_OVER));
  assign w_hit        = collision & (r_state == S_PLAY);
  // A bonus landing with the fatal hit keeps the bird alive, so it still goes invulnerable
  assign w_timer_load = w_hit & (w_bonus | (r_lives > 4'd1));

`ifdef BONUS_LIFE_EN
  logic [7:0] r_points;
  logic       w_scoring;

  assign w_scoring = score_tick & ((r_state == S_PLAY) | (r_state == S_INVULN));
  assign w_bonus   = w_scoring & (r_points + 8'd1 >= BONUS_POINTS);

  // Accumulate pipes passed; wraps to zero each time a life is awarded and on a new game
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_points <= 8'd0;
    end else if (w_start) begin
      r_points <= 8'd0;
    end else if (w_scoring) begin
      r_points <= w_bonus ? 8'd0 : r_points + 8'd1;
    end
  end
`else
  logic w_unused_bonus;

  assign w_bonus        = 1'b0;
  assign w_unused_bonus = score_tick ^ (BONUS_POINTS == 8'd0);
`endif

  life_invuln_timer #(
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_FRAMES  (BLINK_FRAMES)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_timer_load),
    .i_run        (r_state == S_INVULN),
    .i_frame_tick (frame_tick),
    .o_done       (w_timer_done),
    .o_blink      (w_blink)
  );

  // Game state, life count and the registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_lives      <= 4'd0;
      r_invincible <= 1'b0;
      r_pulse      <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start) begin
            r_state      <= S_PLAY;
            r_lives      <= LOAD_LIVES;
            r_invincible <= 1'b0;
            r_game_over  <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_hit) begin
            r_pulse <= 1'b1;
            if (w_timer_load) begin
              r_state      <= S_INVULN;
              r_invincible <= 1'b1;
              if (!w_bonus) r_lives <= r_lives - 4'd1;
            end else begin
              r_state     <= S_OVER;
              r_lives     <= 4'd0;
              r_game_over <= 1'b1;
            end
          end else if (w_bonus) begin
            r_lives <= sat_inc(r_lives, MAX_LIVES);
          end
        end
        S_INVULN: begin
          if (w_timer_done) begin
            r_state      <= S_PLAY;
            r_invincible <= 1'b0;
          end
          if (w_bonus) r_lives <= sat_inc(r_lives, MAX_LIVES);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign life_number     = min_lives(r_lives, MAX_LIVES);
  assign invincible      = r_invincible;
  assign life_blink      = w_blink;
  assign life_lost_pulse = r_pulse;
  assign game_over       = r_game_over;

endmodule

// File: tb/tb_life_counter.sv
// tb/tb_life_counter.sv - directed and model-checked bench for life_counter
module tb_life_counter;

  localparam int INIT   = 3;
  localparam int MAXL   = 9;
  localparam int INV_FR = 4;
  localparam int BLINK  = 2;
  localparam int BPTS   = 2;
  localparam int M_IDLE = 0, M_PLAY = 1, M_INV = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0, collision = 1'b0, frame_tick = 1'b0, score_tick = 1'b0;
  logic [3:0] life_number;
  logic       invincible, life_blink, life_lost_pulse, game_over;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int m_mode, m_lives, m_inv_left, m_inv_ticks, m_points;
  bit m_pulse;

  life_counter #(
    .INIT_LIVES    (4'd3),
    .MAX_LIVES     (4'd9),
    .INVULN_FRAMES (8'd4),
    .BLINK_FRAMES  (4'd2),
    .BONUS_POINTS  (8'd2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .game_start      (game_start),
    .collision       (collision),
    .frame_tick      (frame_tick),
    .score_tick      (score_tick),
    .life_number     (life_number),
    .invincible      (invincible),
    .life_blink      (life_blink),
    .life_lost_pulse (life_lost_pulse),
    .game_over       (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = 0; m_inv_left = 0; m_inv_ticks = 0; m_points = 0; m_pulse = 0;
  endtask

  function automatic int exp_blink();
    if (m_mode != M_INV) return 0;
    return (((m_inv_ticks / BLINK) % 2) == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input bit gs, input bit col, input bit ft, input bit st);
    bit bonus;
    bonus   = 0;
    m_pulse = 0;
`ifdef BONUS_LIFE_EN
    if (st && (m_mode == M_PLAY || m_mode == M_INV)) begin
      m_points++;
      if (m_points == BPTS) begin m_points = 0; bonus = 1; end
    end
`endif
    case (m_mode)
      M_IDLE, M_OVER: if (gs) begin m_mode = M_PLAY; m_lives = INIT; m_points = 0; end
      M_PLAY: begin
        if (col) begin
          m_pulse = 1;
          if (!bonus) m_lives = m_lives - 1;
          if (m_lives == 0) m_mode = M_OVER;
          else begin m_mode = M_INV; m_inv_left = INV_FR; m_inv_ticks = 0; end
        end else if (bonus) begin
          m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
        end
      end
      default: begin
        if (bonus) m_lives = (m_lives < MAXL) ? m_lives + 1 : MAXL;
        if (ft) begin
          m_inv_ticks++;
          m_inv_left--;
          if (m_inv_left == 0) m_mode = M_PLAY;
        end
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge
  task automatic cyc(input bit gs, input bit col, input bit ft, input bit st);
    game_start = gs; collision = col; frame_tick = ft; score_tick = st;
    @(posedge clk);
    model_step(gs, col, ft, st);
    @(negedge clk);
    game_start = 0; collision = 0; frame_tick = 0; score_tick = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " life_number"}, life_number, 0);
    check({tag, " invincible"}, invincible, 0);
    check({tag, " life_blink"}, life_blink, 0);
    check({tag, " life_lost_pulse"}, life_lost_pulse, 0);
    check({tag, " game_over"}, game_over, 0);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock
  task automatic mid_reset();
    #2 rst_n = 0;
    model_reset();
    #1 check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model life_number", life_number, m_lives);
      check("model invincible", invincible, (m_mode == M_INV) ? 1 : 0);
      check("model life_blink", life_blink, exp_blink());
      check("model life_lost_pulse", life_lost_pulse, m_pulse);
      check("model game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", n_checks);
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n  = 1;
    chk_en = 1;

    cyc(0, 1, 1, 1);
    check("idle collision ignored", life_lost_pulse, 0);
    cyc(1, 0, 0, 0);
    check("start life_number", life_number, 3);
    check("start game_over", game_over, 0);
    check("start invincible", invincible, 0);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    check("hit life_number", life_number, 2);
    check("hit pulse", life_lost_pulse, 1);
    check("hit invincible", invincible, 1);
    check("blink frame1", life_blink, 1);
    cyc(0, 0, 0, 0);
    check("pulse one cycle", life_lost_pulse, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check("invuln hit life_number", life_number, 2);
    check("invuln hit pulse", life_lost_pulse, 0);

    cyc(0, 0, 1, 0);
    check("blink frame2", life_blink, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    check("blink frame3", life_blink, 0);
    cyc(0, 0, 1, 0);
    check("blink frame4", life_blink, 0);
    check("still invincible", invincible, 1);
    cyc(0, 0, 1, 0);
    check("window over invincible", invincible, 0);
    check("window over blink", life_blink, 0);

    cyc(1, 0, 0, 0);
    check("start in play ignored", life_number, 2);

    cyc(0, 1, 0, 0);
    check("second hit life_number", life_number, 1);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    check("hit at exit invincible", invincible, 0);
    check("hit at exit pulse", life_lost_pulse, 0);
    check("hit at exit life_number", life_number, 1);

    cyc(0, 1, 0, 0);
    check("last life life_number", life_number, 0);
    check("last life game_over", game_over, 1);
    check("last life pulse", life_lost_pulse, 1);
    cyc(0, 1, 1, 1);
    check("over hit pulse", life_lost_pulse, 0);
    check("over life_number", life_number, 0);

    cyc(1, 1, 0, 0);
    check("restart life_number", life_number, 3);
    check("restart pulse", life_lost_pulse, 0);
    check("restart game_over", game_over, 0);

    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    check("pre-reset invincible", invincible, 1);
    mid_reset();
    cyc(0, 1, 0, 0);
    check("post-reset hit pulse", life_lost_pulse, 0);
    check("post-reset life_number", life_number, 0);
    cyc(1, 0, 0, 0);
    check("post-reset start", life_number, 3);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

`ifdef BONUS_LIFE_EN
    mid_reset();
    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 1);
    check("bonus reaches max", life_number, 9);
    repeat (2) cyc(0, 0, 0, 1);
    check("bonus saturates", life_number, 9);
    for (int k = 0; k < 8; k++) begin
      cyc(0, 1, 0, 0);
      repeat (4) cyc(0, 0, 1, 0);
    end
    check("down to one", life_number, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("bonus+hit life_number", life_number, 1);
    check("bonus+hit invincible", invincible, 1);
    check("bonus+hit pulse", life_lost_pulse, 1);
    check("bonus+hit game_over", game_over, 0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
